// File: rtl/prop_violation_logger.sv
// Synthesizable checker for the invariant "q != d" on a registered stage.
// Counts violations, keeps a sticky fail state and logs the first events in a small FIFO.
module prop_violation_logger #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16,
    parameter int TS_W  = 16,
    parameter int DEPTH = 4
) (
    input  logic             mclk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [TS_W-1:0]  ev_ts,
    output logic [WIDTH-1:0] ev_data,
    output logic [CNT_W-1:0] viol_cnt,
    output logic             overflow,
    output logic [1:0]       state
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [TS_W-1:0]  TS_ONE  = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        FAILED = 2'd2
    } state_t;

    state_t           state_q;
    logic [TS_W-1:0]  ts_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic [TS_W-1:0]  mem_ts_q   [DEPTH];
    logic [WIDTH-1:0] mem_data_q [DEPTH];

    logic checked;
    logic viol;
    logic empty;
    logic full;
    logic pop;
    logic push;

    // The enable gate sits first so unknown q/d in unchecked cycles cannot reach any state.
    assign checked = en && (state_q != IDLE);
    assign viol    = checked && (q == d);
    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop     = !empty && ev_ready;
    assign push    = viol && (!full || pop);

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ts_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else if (clr) begin
            state_q <= IDLE;
            ts_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            ts_q <= ts_q + TS_ONE;
            if (viol && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
            if (viol && full && !pop) begin
                ovf_q <= 1'b1;
            end
            if (push) begin
                wr_q <= wr_q + PTR_ONE;
            end
            if (pop) begin
                rd_q <= rd_q + PTR_ONE;
            end
            unique case (state_q)
                IDLE:    if (en) state_q <= ARMED;
                ARMED: begin
                    if (viol) begin
                        state_q <= FAILED;
                    end else if (!en) begin
                        state_q <= IDLE;
                    end
                end
                FAILED:  state_q <= FAILED;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Storage is cleared as well so the head outputs read zero after reset or clear.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_ts_q[i]   <= '0;
                mem_data_q[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_ts_q[i]   <= '0;
                mem_data_q[i] <= '0;
            end
        end else if (push) begin
            mem_ts_q[wr_q[AW-1:0]]   <= ts_q;
            mem_data_q[wr_q[AW-1:0]] <= q;
        end
    end

    assign ev_valid = !empty;
    assign ev_ts    = mem_ts_q[rd_q[AW-1:0]];
    assign ev_data  = mem_data_q[rd_q[AW-1:0]];
    assign viol_cnt = cnt_q;
    assign overflow = ovf_q;
    assign state    = state_q;

endmodule

// File: tb/tb_prop_violation_logger.sv
// Bench for prop_violation_logger: a default instance and a narrow-counter instance share stimulus
// and are checked against directed vectors and a queue-based reference model.
module tb_prop_violation_logger;

    logic        mclk = 1'b0;
    logic        rstN;
    logic        en;
    logic        clr;
    logic [0:0]  qIn;
    logic [0:0]  dIn;
    logic        evReady;

    logic        evValid;
    logic [15:0] evTs;
    logic [0:0]  evData;
    logic [15:0] violCnt;
    logic        overflowO;
    logic [1:0]  stateO;

    logic        sValid;
    logic [3:0]  sTs;
    logic [0:0]  sData;
    logic [2:0]  sCnt;
    logic        sOverflow;
    logic [1:0]  sState;

    int nChecks = 0;
    int nPass   = 0;

    always #5 mclk = ~mclk;

    prop_violation_logger #(.WIDTH(1), .CNT_W(16), .TS_W(16), .DEPTH(4)) dut (
        .mclk(mclk), .rst_n(rstN), .en(en), .clr(clr), .q(qIn), .d(dIn),
        .ev_valid(evValid), .ev_ready(evReady), .ev_ts(evTs), .ev_data(evData),
        .viol_cnt(violCnt), .overflow(overflowO), .state(stateO)
    );

    prop_violation_logger #(.WIDTH(1), .CNT_W(3), .TS_W(4), .DEPTH(4)) dutSmall (
        .mclk(mclk), .rst_n(rstN), .en(en), .clr(clr), .q(qIn), .d(dIn),
        .ev_valid(sValid), .ev_ready(evReady), .ev_ts(sTs), .ev_data(sData),
        .viol_cnt(sCnt), .overflow(sOverflow), .state(sState)
    );

    // Reference model: unbounded timestamp and count, truncated/saturated only when compared.
    typedef struct {
        int   ts;
        logic data;
    } entry_t;

    int     mState;
    int     mTs;
    int     mCnt;
    bit     mOvf;
    entry_t mFifo[$];

    task automatic modelReset();
        mState = 0;
        mTs    = 0;
        mCnt   = 0;
        mOvf   = 0;
        mFifo.delete();
    endtask

    task automatic modelStep();
        bit     viol;
        entry_t e;
        if (clr) begin
            modelReset();
        end else begin
            viol = en && (mState != 0) && (qIn == dIn);
            if (mFifo.size() > 0 && evReady) begin
                void'(mFifo.pop_front());
            end
            if (viol) begin
                mCnt++;
                if (mFifo.size() < 4) begin
                    e.ts   = mTs;
                    e.data = qIn[0];
                    mFifo.push_back(e);
                end else begin
                    mOvf = 1;
                end
            end
            if (mState == 0 && en) mState = 1;
            else if (mState == 1 && viol) mState = 2;
            else if (mState == 1 && !en) mState = 0;
            mTs++;
        end
    endtask

    task automatic checkVal(input string name, input longint act, input longint exp);
        nChecks++;
        if (act == exp) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string tag);
        int cap;
        checkVal({tag, " valid"}, evValid, mFifo.size() > 0);
        checkVal({tag, " cnt"}, violCnt, (mCnt > 65535) ? 65535 : mCnt);
        checkVal({tag, " ovf"}, overflowO, mOvf);
        checkVal({tag, " state"}, stateO, mState);
        cap = (mCnt > 7) ? 7 : mCnt;
        checkVal({tag, " small valid"}, sValid, mFifo.size() > 0);
        checkVal({tag, " small cnt"}, sCnt, cap);
        checkVal({tag, " small ovf"}, sOverflow, mOvf);
        checkVal({tag, " small state"}, sState, mState);
        if (mFifo.size() > 0) begin
            checkVal({tag, " ts"}, evTs, mFifo[0].ts % 65536);
            checkVal({tag, " data"}, evData, mFifo[0].data);
            checkVal({tag, " small ts"}, sTs, mFifo[0].ts % 16);
            checkVal({tag, " small data"}, sData, mFifo[0].data);
        end
    endtask

    task automatic applyStimulus(input bit e, input bit c, input bit qv, input bit dv, input bit r);
        en      = e;
        clr     = c;
        qIn     = qv;
        dIn     = dv;
        evReady = r;
        @(posedge mclk);
        modelStep();
        #1;
    endtask

    typedef struct {
        bit e, c, qv, dv, r;
        int expValid, expTs, expData, expCnt, expState, expOvf;
    } vec_t;

    vec_t vecs[14];

    initial begin
        rstN = 1'b0; en = 1'b0; clr = 1'b0; qIn = '0; dIn = '0; evReady = 1'b0;
        modelReset();
        repeat (2) @(posedge mclk);
        #1;
        checkVal("reset valid", evValid, 0);
        checkVal("reset ts", evTs, 0);
        checkVal("reset data", evData, 0);
        checkVal("reset cnt", violCnt, 0);
        checkVal("reset ovf", overflowO, 0);
        checkVal("reset state", stateO, 0);
        @(negedge mclk);
        rstN = 1'b1;

        // Arm, first violation at timestamp 5, pause in FAILED, pops, clear, re-arm.
        vecs[0]  = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0};
        vecs[1]  = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0};
        vecs[2]  = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0};
        vecs[3]  = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0};
        vecs[4]  = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0};
        vecs[5]  = '{1, 0, 1, 1, 0, 1, 5, 1, 1, 2, 0};
        vecs[6]  = '{0, 0, 1, 1, 0, 1, 5, 1, 1, 2, 0};
        vecs[7]  = '{1, 0, 1, 1, 0, 1, 5, 1, 2, 2, 0};
        vecs[8]  = '{1, 0, 0, 1, 1, 1, 7, 1, 2, 2, 0};
        vecs[9]  = '{1, 0, 0, 0, 1, 1, 9, 0, 3, 2, 0};
        vecs[10] = '{0, 0, 0, 1, 1, 0, 0, 0, 3, 2, 0};
        vecs[11] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        vecs[12] = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0};
        vecs[13] = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 2, 0};
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].e, vecs[i].c, vecs[i].qv, vecs[i].dv, vecs[i].r);
            checkVal($sformatf("vec%0d valid", i), evValid, vecs[i].expValid);
            checkVal($sformatf("vec%0d cnt", i), violCnt, vecs[i].expCnt);
            checkVal($sformatf("vec%0d state", i), stateO, vecs[i].expState);
            checkVal($sformatf("vec%0d ovf", i), overflowO, vecs[i].expOvf);
            if (vecs[i].expValid != 0) begin
                checkVal($sformatf("vec%0d ts", i), evTs, vecs[i].expTs);
                checkVal($sformatf("vec%0d data", i), evData, vecs[i].expData);
            end
        end

        // Six violations into a four-entry FIFO with no reader.
        applyStimulus(1, 1, 0, 1, 0);
        applyStimulus(1, 0, 0, 1, 0);
        repeat (6) applyStimulus(1, 0, 0, 0, 0);
        checkVal("ovfseq cnt", violCnt, 6);
        checkVal("ovfseq ovf", overflowO, 1);
        checkOutput("ovfseq");
        for (int i = 1; i <= 4; i++) begin
            checkVal($sformatf("drain%0d valid", i), evValid, 1);
            checkVal($sformatf("drain%0d ts", i), evTs, i);
            applyStimulus(0, 0, 0, 1, 1);
        end
        checkVal("drain empty", evValid, 0);
        checkVal("drain ovf sticky", overflowO, 1);

        // Full FIFO plus violation with a same-cycle pop must not drop.
        applyStimulus(1, 1, 0, 1, 0);
        applyStimulus(1, 0, 0, 1, 0);
        repeat (4) applyStimulus(1, 0, 1, 1, 0);
        applyStimulus(1, 0, 1, 1, 1);
        checkVal("fullpop ovf", overflowO, 0);
        checkVal("fullpop cnt", violCnt, 5);
        for (int i = 2; i <= 5; i++) begin
            checkVal($sformatf("fullpop%0d valid", i), evValid, 1);
            checkVal($sformatf("fullpop%0d ts", i), evTs, i);
            applyStimulus(0, 0, 0, 1, 1);
        end
        checkVal("fullpop empty", evValid, 0);

        // Narrow counter saturation.
        applyStimulus(1, 1, 0, 1, 0);
        applyStimulus(1, 0, 0, 1, 0);
        repeat (9) applyStimulus(1, 0, 0, 0, 1);
        checkVal("sat small cnt", sCnt, 7);
        checkVal("sat main cnt", violCnt, 9);
        checkOutput("sat");

        // Narrow timestamp wrap: violation sampled at timestamp 17.
        applyStimulus(1, 1, 0, 1, 0);
        repeat (17) applyStimulus(1, 0, 0, 1, 0);
        applyStimulus(1, 0, 1, 1, 0);
        checkVal("wrap small valid", sValid, 1);
        checkVal("wrap small ts", sTs, 1);
        checkVal("wrap main ts", evTs, 17);
        checkOutput("wrap");

        // Asynchronous reset mid-operation.
        repeat (3) applyStimulus(1, 0, 0, 0, 0);
        #2;
        rstN = 1'b0;
        #1;
        modelReset();
        checkVal("midrst valid", evValid, 0);
        checkVal("midrst cnt", violCnt, 0);
        checkVal("midrst state", stateO, 0);
        checkVal("midrst ts", evTs, 0);
        checkVal("midrst data", evData, 0);
        checkVal("midrst ovf", overflowO, 0);
        @(negedge mclk);
        rstN = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(7) != 0, $urandom_range(40) == 0,
                          1'($urandom_range(1)), 1'($urandom_range(1)),
                          1'($urandom_range(1)));
            checkOutput($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
